// File: rtl/dispatcher_exp_unpack_ctrl_if.sv
// Packed-exponent read port plus left/right aligned-exponent write ports
// shared between the unpack sequencer (master) and the dispatcher BRAM (slave).
interface dispatcher_exp_unpack_ctrl_if #(
  parameter int DATA_WIDTH   = 256,
  parameter int EXP_WIDTH    = 8,
  parameter int PACKED_DEPTH = 16
);
  localparam int RD_AW = $clog2(PACKED_DEPTH);
  localparam int WR_AW = $clog2(PACKED_DEPTH * (DATA_WIDTH / EXP_WIDTH));

  logic [RD_AW-1:0]      exp_packed_rd_addr;
  logic                  exp_packed_rd_target;
  logic [DATA_WIDTH-1:0] exp_packed_rd_data;
  logic [WR_AW-1:0]      left_exp_aligned_wr_addr;
  logic [EXP_WIDTH-1:0]  left_exp_aligned_wr_data;
  logic                  left_exp_aligned_wr_en;
  logic [WR_AW-1:0]      right_exp_aligned_wr_addr;
  logic [EXP_WIDTH-1:0]  right_exp_aligned_wr_data;
  logic                  right_exp_aligned_wr_en;

  modport master (
    output exp_packed_rd_addr, exp_packed_rd_target,
    input  exp_packed_rd_data,
    output left_exp_aligned_wr_addr, left_exp_aligned_wr_data, left_exp_aligned_wr_en,
    output right_exp_aligned_wr_addr, right_exp_aligned_wr_data, right_exp_aligned_wr_en
  );

  modport slave (
    input  exp_packed_rd_addr, exp_packed_rd_target,
    output exp_packed_rd_data,
    input  left_exp_aligned_wr_addr, left_exp_aligned_wr_data, left_exp_aligned_wr_en,
    input  right_exp_aligned_wr_addr, right_exp_aligned_wr_data, right_exp_aligned_wr_en
  );
endinterface

// File: rtl/dispatcher_exp_unpack_ctrl.sv
// Unpacks the 16 packed exponent lines of one dispatcher side into 512 aligned
// 8-bit exponent writes, one per cycle, following the FETCH line-valid count.
module dispatcher_exp_unpack_ctrl #(
  parameter int DATA_WIDTH   = 256,
  parameter int EXP_WIDTH    = 8,
  parameter int PACKED_DEPTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_start,
  input  logic                             i_target,
  input  logic                             i_abort,
  input  logic [$clog2(PACKED_DEPTH):0]    i_packed_lines_valid,
  output logic                             o_busy,
  output logic                             o_done,
  dispatcher_exp_unpack_ctrl_if.master     bus
);
  localparam int EXPS_PER_LINE = DATA_WIDTH / EXP_WIDTH;
  localparam int LINE_W        = $clog2(PACKED_DEPTH);
  localparam int BYTE_W        = $clog2(EXPS_PER_LINE);
  localparam int VALID_W       = LINE_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, EMIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [LINE_W-1:0]     line_reg, line_next;
  logic [BYTE_W-1:0]     byte_reg, byte_next;
  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
  logic                  target_reg, target_next;

  logic [VALID_W-1:0]    valid_sat;
  logic                  line_ready;

  assign valid_sat  = (i_packed_lines_valid > VALID_W'(PACKED_DEPTH)) ?
                      VALID_W'(PACKED_DEPTH) : i_packed_lines_valid;
  assign line_ready = valid_sat > {1'b0, line_reg};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg  <= IDLE;
      line_reg   <= '0;
      byte_reg   <= '0;
      shreg_reg  <= '0;
      target_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      line_reg   <= line_next;
      byte_reg   <= byte_next;
      shreg_reg  <= shreg_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    line_next   = line_reg;
    byte_next   = byte_reg;
    shreg_next  = shreg_reg;
    target_next = target_reg;
    case (state_reg)
      IDLE: begin
        if (i_start && !i_abort) begin
          target_next = i_target;
          line_next   = '0;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        // Read data is combinational on line_reg, so capture happens the same cycle.
        if (line_ready) begin
          shreg_next = bus.exp_packed_rd_data;
          byte_next  = '0;
          state_next = EMIT;
        end
      end
      EMIT: begin
        shreg_next = shreg_reg >> EXP_WIDTH;
        byte_next  = byte_reg + BYTE_W'(1);
        if (byte_reg == BYTE_W'(EXPS_PER_LINE - 1)) begin
          if (line_reg == LINE_W'(PACKED_DEPTH - 1)) begin
            state_next = DONE;
          end else begin
            line_next  = line_reg + LINE_W'(1);
            state_next = WAIT;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE && i_abort) begin
      state_next = IDLE;
    end
  end

  logic [1:0]                 side_en;
  logic [LINE_W+BYTE_W-1:0]   wr_addr;
  logic [EXP_WIDTH-1:0]       wr_data;

  assign wr_addr = {line_reg, byte_reg};
  assign wr_data = shreg_reg[EXP_WIDTH-1:0];

  // Write strobes depend only on registered state; side 0 is left, side 1 is right.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      assign side_en[gi] = (state_reg == EMIT) && (target_reg == 1'(gi));
    end
  endgenerate

  assign bus.left_exp_aligned_wr_en    = side_en[0];
  assign bus.left_exp_aligned_wr_addr  = side_en[0] ? wr_addr : '0;
  assign bus.left_exp_aligned_wr_data  = side_en[0] ? wr_data : '0;
  assign bus.right_exp_aligned_wr_en   = side_en[1];
  assign bus.right_exp_aligned_wr_addr = side_en[1] ? wr_addr : '0;
  assign bus.right_exp_aligned_wr_data = side_en[1] ? wr_data : '0;

  assign bus.exp_packed_rd_addr   = line_reg;
  assign bus.exp_packed_rd_target = target_reg;
  assign o_busy = (state_reg != IDLE);
  assign o_done = (state_reg == DONE);
endmodule

// File: tb/tb_dispatcher_exp_unpack_ctrl.sv
// Scoreboard bench: runs push expected writes/done pulses with their cycle
// numbers, and a negedge monitor pops and compares whatever the DUT emits.
module tb_dispatcher_exp_unpack_ctrl;
  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_target = 1'b0;
  logic       i_abort = 1'b0;
  logic [4:0] i_packed_lines_valid = 5'd16;
  logic       o_busy;
  logic       o_done;

  dispatcher_exp_unpack_ctrl_if bus ();

  dispatcher_exp_unpack_ctrl dut (
    .i_clk                (i_clk),
    .i_reset_n            (i_reset_n),
    .i_start              (i_start),
    .i_target             (i_target),
    .i_abort              (i_abort),
    .i_packed_lines_valid (i_packed_lines_valid),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .bus                  (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic       side;
    logic [8:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  logic [255:0] packed_mem [2][16];
  assign bus.exp_packed_rd_data = packed_mem[bus.exp_packed_rd_target][bus.exp_packed_rd_addr];

  function automatic logic [7:0] pat(input logic s, input int idx);
    return s ? 8'((idx * 5 + 17) & 255) : 8'(idx & 255);
  endfunction

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge i_clk) begin
    logic       s;
    logic [8:0] a, ua;
    logic [7:0] d, ud;
    wr_t        e;
    if (bus.left_exp_aligned_wr_en || bus.right_exp_aligned_wr_en) begin
      s  = bus.right_exp_aligned_wr_en;
      a  = s ? bus.right_exp_aligned_wr_addr : bus.left_exp_aligned_wr_addr;
      d  = s ? bus.right_exp_aligned_wr_data : bus.left_exp_aligned_wr_data;
      ua = s ? bus.left_exp_aligned_wr_addr  : bus.right_exp_aligned_wr_addr;
      ud = s ? bus.left_exp_aligned_wr_data  : bus.right_exp_aligned_wr_data;
      n_cmp++;
      if (bus.left_exp_aligned_wr_en && bus.right_exp_aligned_wr_en) begin
        n_err++;
        $display("FAIL wr_both_sides: got both wr_en high at cyc=%0d, want one side", cyc);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got side=%0d addr=%0d data=%0h cyc=%0d, want no write", s, a, d, cyc);
      end else begin
        e = exp_q.pop_front();
        if (s !== e.side || a !== e.addr || d !== e.data || cyc != e.cyc || ua !== 9'd0 || ud !== 8'd0) begin
          n_err++;
          $display("FAIL wr_match: got side=%0d addr=%0d data=%0h cyc=%0d other=%0d/%0h, want side=%0d addr=%0d data=%0h cyc=%0d other=0/0",
                   s, a, d, cyc, ua, ud, e.side, e.addr, e.data, e.cyc);
        end
      end
    end
    if (o_done) begin
      n_cmp++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got o_done=1 at cyc=%0d, want none", cyc);
      end else if (cyc != done_q[0]) begin
        n_err++;
        $display("FAIL done_cycle: got cyc=%0d, want cyc=%0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic int outputs_or();
    return int'(o_busy | o_done | bus.exp_packed_rd_target
               | (|bus.exp_packed_rd_addr)
               | bus.left_exp_aligned_wr_en  | (|bus.left_exp_aligned_wr_addr)  | (|bus.left_exp_aligned_wr_data)
               | bus.right_exp_aligned_wr_en | (|bus.right_exp_aligned_wr_addr) | (|bus.right_exp_aligned_wr_data));
  endfunction

  // One run: schedule model (capture cycle = max(ready, first valid cycle)),
  // optional abort / mid-run start / async reset at given relative cycles.
  task automatic do_run(input logic side, input bit stag, input int abort_r,
                        input int start_r, input int rst_r);
    int  base, t, cap, wc, cutoff, limit;
    wr_t e;
    cutoff = (abort_r > 0) ? abort_r : rst_r;
    @(negedge i_clk);
    base = cyc;
    i_start = 1'b1;
    i_target = side;
    i_packed_lines_valid = stag ? 5'd0 : 5'd16;
    t = 1;
    for (int k = 0; k < 16; k++) begin
      cap = t;
      if (stag && cap < 40 * (k + 1)) cap = 40 * (k + 1);
      for (int b = 0; b < 32; b++) begin
        wc = cap + 1 + b;
        if (cutoff == 0 || wc <= cutoff) begin
          e.side = side;
          e.addr = 9'(k * 32 + b);
          e.data = pat(side, k * 32 + b);
          e.cyc  = base + wc;
          exp_q.push_back(e);
        end
      end
      t = cap + 33;
    end
    if (cutoff == 0) done_q.push_back(base + t);
    limit = (cutoff > 0) ? cutoff + 4 : t + 2;
    for (int r = 1; r <= limit; r++) begin
      @(negedge i_clk);
      i_start  = (r == start_r);
      i_target = (r == start_r) ? ~side : 1'b0;
      i_abort  = (abort_r > 0 && r == abort_r);
      if (stag) i_packed_lines_valid = (r / 40 > 16) ? 5'd16 : 5'(r / 40);
      if (abort_r > 0 && r == abort_r + 1) check("busy_after_abort", int'(o_busy), 0);
      if (rst_r > 0 && r == rst_r) begin
        #2 i_reset_n = 1'b0;
        #1 check("outputs_in_async_reset", outputs_or(), 0);
      end
      if (rst_r > 0 && r == rst_r + 2) i_reset_n = 1'b1;
      if (rst_r > 0 && r == rst_r + 3) check("busy_after_reset", int'(o_busy), 0);
    end
    check("writes_pending", exp_q.size(), 0);
    check("done_pending", done_q.size(), 0);
    check("busy_at_end", int'(o_busy), 0);
    exp_q.delete();
    done_q.delete();
    i_packed_lines_valid = 5'd16;
    $display("run side=%0d stag=%0d abort=%0d start=%0d rst=%0d finished at cyc=%0d", side, stag, abort_r, start_r, rst_r, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 16; l++)
        for (int b = 0; b < 32; b++)
          packed_mem[s][l][8*b +: 8] = pat(1'(s), l * 32 + b);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check("reset_state_outputs", outputs_or(), 0);

    do_run(1'b0, 1'b0, 0,   0,   0);    // left, all lines valid
    do_run(1'b0, 1'b0, 177, 0,   0);    // abort at line 5 byte 10
    do_run(1'b1, 1'b0, 0,   0,   0);    // restart from addr 0, right side
    do_run(1'b1, 1'b1, 0,   0,   0);    // right, staggered line arrival
    do_run(1'b0, 1'b0, 0,   100, 0);    // start while busy is ignored
    do_run(1'b1, 1'b0, 0,   0,   106);  // async reset during line 3
    do_run(1'b0, 1'b0, 0,   0,   0);    // fresh run after reset

    @(negedge i_clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    i_target = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    i_target = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("busy_after_start_abort", int'(o_busy), 0);
      @(negedge i_clk);
    end
    $display("start+abort in idle checked at cyc=%0d", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
